// File: rtl/iadc_ctrl_serializer_if.sv
// ----------------------------------------------------------------------------
// iadc_ctrl_serializer_if
//
// Command handshake between the iadc_controller register file (master) and
// the serial control-port engine (slave).
//
//   start_i  master->slave  one-cycle request to send a command
//   addr_i   master->slave  3-bit control address, sampled with start_i
//   data_i   master->slave  16-bit control data, sampled with start_i
//   busy_o   slave->master  transaction in progress
//   done_o   slave->master  one-cycle completion pulse
// ----------------------------------------------------------------------------
interface iadc_ctrl_serializer_if;
    logic        start_i;
    logic [2:0]  addr_i;
    logic [15:0] data_i;
    logic        busy_o;
    logic        done_o;

    modport master (
        output start_i,
        output addr_i,
        output data_i,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  start_i,
        input  addr_i,
        input  data_i,
        output busy_o,
        output done_o
    );
endinterface

// File: rtl/iadc_ctrl_serializer.sv
// ----------------------------------------------------------------------------
// iadc_ctrl_serializer
//
// Serial control-port engine for the iADC. On start it shifts {addr, data}
// (19 bits) MSB-first onto adc_ctrl_data with a framing strobe, follows with
// one commit period (ADC latches the word) and one release period (strobe
// high), then pulses done.
//
// Parameter:
//   CLK_DIV  wb_clk_i cycles per half period of adc_ctrl_clk (1..255)
//
// Ports:
//   wb_clk_i           system clock
//   wb_rst_n_i         asynchronous active-low reset
//   ctrl (slave)       start_i/addr_i/data_i in, busy_o/done_o out
//   adc_ctrl_clk       serial clock, ADC samples on the rising edge
//   adc_ctrl_data      serial data, MSB first
//   adc_ctrl_strobe_n  active-low frame strobe
//
// Optional build macro IADC_CTRL_QUEUE_EN: adds a one-entry pending command
// buffer so a start received while busy is sent right after the current
// frame (last write wins), with no IDLE cycle in between.
// ----------------------------------------------------------------------------
module iadc_ctrl_serializer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_n_i,
    iadc_ctrl_serializer_if.slave        ctrl,
    output logic                         adc_ctrl_clk,
    output logic                         adc_ctrl_data,
    output logic                         adc_ctrl_strobe_n
);

    // Phase counter spans one full serial period: 0..2*CLK_DIV-1.
    localparam int unsigned     PH_W     = $clog2(CLK_DIV) + 1;
    localparam logic [PH_W-1:0] PH_RISE  = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [4:0]      LAST_BIT = 5'd18;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        COMMIT  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] ph_q,    ph_d;
    logic [4:0]      bit_q,   bit_d;
    logic [18:0]     shift_q, shift_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic            sclk_q,  sclk_d;
    logic            sdata_q, sdata_d;
    logic            strb_q,  strb_d;

    logic            launch;
    logic [18:0]     launch_word;

`ifdef IADC_CTRL_QUEUE_EN
    logic            pend_q,  pend_d;
    logic [18:0]     pword_q, pword_d;
`endif

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sclk_d      = sclk_q;
        sdata_d     = sdata_q;
        strb_d      = strb_q;
        launch      = 1'b0;
        launch_word = {ctrl.addr_i, ctrl.data_i};
`ifdef IADC_CTRL_QUEUE_EN
        pend_d      = pend_q;
        pword_d     = pword_q;
`endif

        if (state_q == IDLE) begin
            launch = ctrl.start_i;
        end else begin
            ph_d = ph_q + 1'b1;
            if (ph_q == PH_RISE) begin
                sclk_d = 1'b1;
            end

`ifdef IADC_CTRL_QUEUE_EN
            // Capture while busy; overwritten by any later start.
            if (ctrl.start_i) begin
                pend_d  = 1'b1;
                pword_d = {ctrl.addr_i, ctrl.data_i};
            end
`endif

            // Data and strobe only move here, at the start of a low phase.
            if (ph_q == PH_LAST) begin
                ph_d   = '0;
                sclk_d = 1'b0;
                case (state_q)
                    SHIFT: begin
                        if (bit_q == LAST_BIT) begin
                            state_d = COMMIT;
                            sdata_d = 1'b0;
                        end else begin
                            bit_d   = bit_q + 5'd1;
                            shift_d = {shift_q[17:0], 1'b0};
                            sdata_d = shift_q[17];
                        end
                    end
                    COMMIT: begin
                        state_d = RELEASE;
                        strb_d  = 1'b1;
                        sdata_d = 1'b0;
                    end
                    RELEASE: begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        strb_d  = 1'b1;
                        sdata_d = 1'b0;
`ifdef IADC_CTRL_QUEUE_EN
                        // A start arriving now is newer than the buffer.
                        if (ctrl.start_i) begin
                            launch = 1'b1;
                        end else if (pend_q) begin
                            launch      = 1'b1;
                            launch_word = pword_q;
                        end
                        pend_d = 1'b0;
`endif
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end

        if (launch) begin
            state_d = SHIFT;
            shift_d = launch_word;
            sdata_d = launch_word[18];
            strb_d  = 1'b0;
            busy_d  = 1'b1;
            bit_d   = '0;
            ph_d    = '0;
            sclk_d  = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            strb_q  <= 1'b1;
`ifdef IADC_CTRL_QUEUE_EN
            pend_q  <= 1'b0;
            pword_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            strb_q  <= strb_d;
`ifdef IADC_CTRL_QUEUE_EN
            pend_q  <= pend_d;
            pword_q <= pword_d;
`endif
        end
    end

    assign ctrl.busy_o       = busy_q;
    assign ctrl.done_o       = done_q;
    assign adc_ctrl_clk      = sclk_q;
    assign adc_ctrl_data     = sdata_q;
    assign adc_ctrl_strobe_n = strb_q;

endmodule

// File: tb/tb_iadc_ctrl_serializer.sv
// ----------------------------------------------------------------------------
// tb_iadc_ctrl_serializer
//
// Two instances (CLK_DIV=4 and CLK_DIV=1) share clock and reset; "sel"
// picks which one receives start and which one the ADC model observes.
// ----------------------------------------------------------------------------
module tb_iadc_ctrl_serializer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel   = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  addr  = '0;
    logic [15:0] data  = '0;

    iadc_ctrl_serializer_if if4();
    iadc_ctrl_serializer_if if1();

    assign if4.start_i = start & ~sel;
    assign if4.addr_i  = addr;
    assign if4.data_i  = data;
    assign if1.start_i = start & sel;
    assign if1.addr_i  = addr;
    assign if1.data_i  = data;

    logic c4, d4, s4, c1, d1, s1;

    iadc_ctrl_serializer #(.CLK_DIV(4)) u_dut4 (
        .wb_clk_i          (clk),
        .wb_rst_n_i        (rst_n),
        .ctrl              (if4),
        .adc_ctrl_clk      (c4),
        .adc_ctrl_data     (d4),
        .adc_ctrl_strobe_n (s4)
    );

    iadc_ctrl_serializer #(.CLK_DIV(1)) u_dut1 (
        .wb_clk_i          (clk),
        .wb_rst_n_i        (rst_n),
        .ctrl              (if1),
        .adc_ctrl_clk      (c1),
        .adc_ctrl_data     (d1),
        .adc_ctrl_strobe_n (s1)
    );

    wire m_clk  = sel ? c1 : c4;
    wire m_data = sel ? d1 : d4;
    wire m_strb = sel ? s1 : s4;
    wire m_busy = sel ? if1.busy_o : if4.busy_o;
    wire m_done = sel ? if1.done_o : if4.done_o;

    // ADC model: shifts in on every rising serial edge while strobe is low.
    logic [19:0] sh = '0;
    int low_edges  = 0;
    int high_edges = 0;
    always @(posedge m_clk) begin
        if (m_strb === 1'b0) begin
            low_edges <= low_edges + 1;
            sh        <= {sh[18:0], m_data};
        end else begin
            high_edges <= high_edges + 1;
        end
    end

    // Data/strobe must not move while the serial clock stays high.
    logic pc, pd, ps;
    int   stab_err = 0;
    always @(negedge clk) begin
        if (pc === 1'b1 && m_clk === 1'b1 && (m_data !== pd || m_strb !== ps))
            stab_err <= stab_err + 1;
        pc <= m_clk;
        pd <= m_data;
        ps <= m_strb;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_frame(
        input  logic [2:0]  a,
        input  logic [15:0] d,
        input  bit          pre,
        input  bit          chain,
        input  logic [2:0]  na,
        input  logic [15:0] nd,
        input  int          limit,
        output logic [19:0] w,
        output int          lat,
        output int          nlow,
        output int          nhigh,
        output int          busy_n,
        output int          shigh,
        output bit          first_ok
    );
        int l0, h0;
        l0 = low_edges;
        h0 = high_edges;
        lat = -1; busy_n = 0; shigh = 0; first_ok = 1'b0; w = '0;
        if (!pre) begin
            addr = a; data = d; start = 1'b1;
        end
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                start = 1'b0;
                first_ok = (m_strb === 1'b0 && m_data === a[2] && m_busy === 1'b1 && m_clk === 1'b0);
            end
            if (m_strb === 1'b1) shigh++;
            if (m_done === 1'b1) begin
                lat = k;
                w   = sh;
                if (chain) begin
                    addr = na; data = nd; start = 1'b1;
                end
                break;
            end
            if (m_busy === 1'b1) busy_n++;
        end
        nlow  = low_edges - l0;
        nhigh = high_edges - h0;
    endtask

    typedef struct {
        bit          sel;
        logic [2:0]  a;
        logic [15:0] d;
        logic [18:0] word;
        int          lat;
        int          shigh;
    } vec_t;

    vec_t        vt[6];
    logic [19:0] w;
    int          lat, nlow, nhigh, busy_n, shigh, ndone, l0, dk1, dk2;
    bit          fok;
    logic        busy_at_done, strb_at_done;
    logic [19:0] w1, w2;

    initial begin
        vt[0] = '{1'b0, 3'b110, 16'hdead, 19'h6dead, 169, 9};
        vt[1] = '{1'b0, 3'b001, 16'h0001, 19'h10001, 169, 9};
        vt[2] = '{1'b0, 3'b111, 16'hffff, 19'h7ffff, 169, 9};
        vt[3] = '{1'b1, 3'b101, 16'ha5a5, 19'h5a5a5,  43, 3};
        vt[4] = '{1'b1, 3'b000, 16'h8001, 19'h08001,  43, 3};
        vt[5] = '{1'b0, 3'b100, 16'h0000, 19'h40000, 169, 9};

        // Reset state of both instances
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy4", 32'(if4.busy_o), 32'd0);
        chk("rst_done4", 32'(if4.done_o), 32'd0);
        chk("rst_clk4",  32'(c4), 32'd0);
        chk("rst_data4", 32'(d4), 32'd0);
        chk("rst_strb4", 32'(s4), 32'd1);
        chk("rst_busy1", 32'(if1.busy_o), 32'd0);
        chk("rst_strb1", 32'(s1), 32'd1);
        chk("rst_clk1",  32'(c1), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-frame vectors
        for (int i = 0; i < 6; i++) begin
            sel = vt[i].sel;
            run_frame(vt[i].a, vt[i].d, 1'b0, 1'b0, 3'b0, 16'h0, 400,
                      w, lat, nlow, nhigh, busy_n, shigh, fok);
            chk($sformatf("v%0d_word", i),   32'(w[19:1]), 32'(vt[i].word));
            chk($sformatf("v%0d_commit", i), 32'(w[0]), 32'd0);
            chk($sformatf("v%0d_lat", i),    32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d_nlow", i),   32'(nlow), 32'd20);
            chk($sformatf("v%0d_nhigh", i),  32'(nhigh), 32'd1);
            chk($sformatf("v%0d_busy", i),   32'(busy_n), 32'(vt[i].lat - 1));
            chk($sformatf("v%0d_shigh", i),  32'(shigh), 32'(vt[i].shigh));
            chk($sformatf("v%0d_first", i),  32'(fok), 32'd1);
            chk($sformatf("v%0d_busy_done", i), 32'(m_busy), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_1cyc", i), 32'(m_done), 32'd0);
            repeat (2) @(posedge clk);
            #1;
        end
        sel = 1'b0;

        // Back-to-back: second start in the done cycle
        run_frame(3'b001, 16'h0001, 1'b0, 1'b1, 3'b111, 16'hffff, 400,
                  w, lat, nlow, nhigh, busy_n, shigh, fok);
        chk("b2b1_word",  32'(w[19:1]), 32'h10001);
        chk("b2b1_lat",   32'(lat), 32'd169);
        chk("b2b_gap",    32'(shigh), 32'd9);
        run_frame(3'b111, 16'hffff, 1'b1, 1'b0, 3'b0, 16'h0, 400,
                  w, lat, nlow, nhigh, busy_n, shigh, fok);
        chk("b2b2_word",  32'(w[19:1]), 32'h7ffff);
        chk("b2b2_lat",   32'(lat), 32'd169);
        chk("b2b2_first", 32'(fok), 32'd1);
        chk("b2b2_nlow",  32'(nlow), 32'd20);
        repeat (3) @(posedge clk);
        #1;

        // Start while busy
        ndone = 0; dk1 = -1; dk2 = -1; busy_at_done = 1'bx; strb_at_done = 1'bx;
        w1 = '0; w2 = '0;
        l0 = low_edges;
        addr = 3'b010; data = 16'h1234; start = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (k == 20) begin data = 16'h5678; start = 1'b1; end
            if (k == 21) start = 1'b0;
            if (m_done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    dk1 = k; w1 = sh; busy_at_done = m_busy; strb_at_done = m_strb;
                end else begin
                    dk2 = k; w2 = sh;
                end
            end
        end
        chk("busy_start_w1",  32'(w1[19:1]), 32'h21234);
        chk("busy_start_dk1", 32'(dk1), 32'd169);
`ifdef IADC_CTRL_QUEUE_EN
        chk("queue_ndone",    32'(ndone), 32'd2);
        chk("queue_dk2",      32'(dk2), 32'd337);
        chk("queue_w2",       32'(w2[19:1]), 32'h25678);
        chk("queue_busy_dn",  32'(busy_at_done), 32'd1);
        chk("queue_strb_dn",  32'(strb_at_done), 32'd0);
        chk("queue_nlow",     32'(low_edges - l0), 32'd40);
`else
        chk("drop_ndone",     32'(ndone), 32'd1);
        chk("drop_busy_dn",   32'(busy_at_done), 32'd0);
        chk("drop_strb_dn",   32'(strb_at_done), 32'd1);
        chk("drop_nlow",      32'(low_edges - l0), 32'd20);
`endif
        repeat (2) @(posedge clk);
        #1;

        // Reset during data bit 7 (frame bit 11, high phase)
        addr = 3'b111; data = 16'hffff; start = 1'b1;
        for (int k = 1; k <= 93; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
        end
        chk("abort_pre_clk",  32'(m_clk), 32'd1);
        chk("abort_pre_data", 32'(m_data), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_strb", 32'(m_strb), 32'd1);
        chk("abort_clk",  32'(m_clk), 32'd0);
        chk("abort_data", 32'(m_data), 32'd0);
        chk("abort_busy", 32'(m_busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (m_done === 1'b1) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_idle_busy", 32'(m_busy), 32'd0);
        run_frame(3'b011, 16'hbeef, 1'b0, 1'b0, 3'b0, 16'h0, 400,
                  w, lat, nlow, nhigh, busy_n, shigh, fok);
        chk("after_rst_word", 32'(w[19:1]), 32'h3beef);
        chk("after_rst_lat",  32'(lat), 32'd169);
        chk("after_rst_nlow", 32'(nlow), 32'd20);
        repeat (3) @(posedge clk);
        #1;

        chk("stable_high_phase", 32'(stab_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
